// File: rtl/fft16_output_reorder_pkg.sv
// Shared constants and digit-reversal helper for the 16-point radix-4 FFT pipeline.
// The same values are used by the input select and butterfly stages.
package fft16_output_reorder_pkg;

    localparam int FFT_N     = 16;
    localparam int FFT_LANES = 4;
    localparam int FFT_LOG4  = 2;

    typedef logic [FFT_LOG4-1:0]   digit_t;
    typedef logic [2*FFT_LOG4-1:0] bin_t;

    // Swaps the two radix-4 digits of a 4-bit index.
    function automatic bin_t dig_rev4(input bin_t k);
        return {k[1:0], k[3:2]};
    endfunction

endpackage

// File: rtl/fft16_bank.sv
// One 16-bin buffer of the reorder ping-pong: a 4-lane beat-indexed write port
// and a single combinational read port addressed by natural bin number.
module fft16_bank
    import fft16_output_reorder_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  digit_t                        wr_beat,
    input  logic [FFT_LANES*2*DATA_W-1:0] wr_data,
    input  bin_t                          rd_addr,
    output logic [2*DATA_W-1:0]           rd_data
);

    logic [2*DATA_W-1:0] mem_r [FFT_N];

    // Lane l of beat b holds bin 4*l+b: the arrival order {b,l} digit-reversed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int l = 0; l < FFT_LANES; l++) begin
                mem_r[dig_rev4({wr_beat, digit_t'(l)})] <= wr_data[l*2*DATA_W +: 2*DATA_W];
            end
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/fft16_output_reorder.sv
// FFT output stage: collects 4-lane beats into a ping-pong buffer and streams
// the 16 bins out one per cycle in natural order.
module fft16_output_reorder
    import fft16_output_reorder_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_real_0,
    input  logic [DATA_W-1:0] in_real_1,
    input  logic [DATA_W-1:0] in_real_2,
    input  logic [DATA_W-1:0] in_real_3,
    input  logic [DATA_W-1:0] in_im_0,
    input  logic [DATA_W-1:0] in_im_1,
    input  logic [DATA_W-1:0] in_im_2,
    input  logic [DATA_W-1:0] in_im_3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_real,
    output logic [DATA_W-1:0] out_im,
    output logic [3:0]        out_index,
    output logic              out_last,
    output logic              frame_err
);

    logic [1:0] full_r, full_next_s;
    logic       wbank_r, wbank_next_s;
    logic       rbank_r, rbank_next_s;
    digit_t     wbeat_r, wbeat_next_s;
    bin_t       rcnt_r, rcnt_next_s;
    logic       frame_err_r, frame_err_next_s;

    logic                          in_fire_s;
    logic                          out_fire_s;
    digit_t                        wr_beat_s;
    logic [FFT_LANES*2*DATA_W-1:0] wr_data_s;
    logic [2*DATA_W-1:0]           rd_a_s, rd_b_s, rd_sel_s;

    assign in_ready   = ~full_r[wbank_r];
    assign out_valid  = full_r[rbank_r];
    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = out_valid & out_ready;
    // A start-of-frame always restarts the beat count, dropping any partial frame.
    assign wr_beat_s  = in_sof ? 2'd0 : wbeat_r;
    assign wr_data_s  = {in_real_3, in_im_3, in_real_2, in_im_2,
                         in_real_1, in_im_1, in_real_0, in_im_0};

    // Write and read pointers advance independently; they never touch the same bank.
    always_comb begin
        full_next_s      = full_r;
        wbank_next_s     = wbank_r;
        rbank_next_s     = rbank_r;
        wbeat_next_s     = wbeat_r;
        rcnt_next_s      = rcnt_r;
        frame_err_next_s = frame_err_r;
        if (in_fire_s) begin
            if (wr_beat_s == 2'd3) begin
                full_next_s[wbank_r] = 1'b1;
                wbank_next_s         = ~wbank_r;
                wbeat_next_s         = 2'd0;
            end else begin
                wbeat_next_s = wr_beat_s + 2'd1;
            end
            if (in_sof && (wbeat_r != 2'd0)) begin
                frame_err_next_s = 1'b1;
            end else begin
                frame_err_next_s = frame_err_r;
            end
        end else begin
            wbeat_next_s = wbeat_r;
        end
        if (out_fire_s) begin
            if (rcnt_r == 4'd15) begin
                full_next_s[rbank_r] = 1'b0;
                rbank_next_s         = ~rbank_r;
                rcnt_next_s          = 4'd0;
            end else begin
                rcnt_next_s = rcnt_r + 4'd1;
            end
        end else begin
            rcnt_next_s = rcnt_r;
        end
    end

    // Control state register; bank contents are deliberately left unreset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_r      <= 2'b00;
            wbank_r     <= 1'b0;
            rbank_r     <= 1'b0;
            wbeat_r     <= 2'd0;
            rcnt_r      <= 4'd0;
            frame_err_r <= 1'b0;
        end else begin
            full_r      <= full_next_s;
            wbank_r     <= wbank_next_s;
            rbank_r     <= rbank_next_s;
            wbeat_r     <= wbeat_next_s;
            rcnt_r      <= rcnt_next_s;
            frame_err_r <= frame_err_next_s;
        end
    end

    fft16_bank #(.DATA_W(DATA_W)) u_bank_a (
        .clk     (clk),
        .wr_en   (in_fire_s & ~wbank_r),
        .wr_beat (wr_beat_s),
        .wr_data (wr_data_s),
        .rd_addr (rcnt_r),
        .rd_data (rd_a_s)
    );

    fft16_bank #(.DATA_W(DATA_W)) u_bank_b (
        .clk     (clk),
        .wr_en   (in_fire_s & wbank_r),
        .wr_beat (wr_beat_s),
        .wr_data (wr_data_s),
        .rd_addr (rcnt_r),
        .rd_data (rd_b_s)
    );

    assign rd_sel_s  = rbank_r ? rd_b_s : rd_a_s;
    assign out_real  = rd_sel_s[2*DATA_W-1:DATA_W];
    assign out_im    = rd_sel_s[DATA_W-1:0];
    assign out_index = rcnt_r;
    assign out_last  = (rcnt_r == 4'd15);
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_fft16_output_reorder.sv
// Directed self-checking bench for fft16_output_reorder: a scoreboard of
// expected bins is filled per completed frame and drained by a monitor.
module tb_fft16_output_reorder;

    localparam int DATA_W = 32;

    typedef struct {
        logic [DATA_W-1:0] re;
        logic [DATA_W-1:0] im;
        logic [3:0]        idx;
        logic              last;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid, in_ready, in_sof;
    logic [DATA_W-1:0] in_re [4];
    logic [DATA_W-1:0] in_imv [4];
    logic              out_valid, out_ready, out_last, frame_err;
    logic [DATA_W-1:0] out_real, out_im;
    logic [3:0]        out_index;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    int   acc_cyc = 0;
    int   stalls = 0;
    exp_t exp_q [$];

    fft16_output_reorder #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sof    (in_sof),
        .in_real_0 (in_re[0]),
        .in_real_1 (in_re[1]),
        .in_real_2 (in_re[2]),
        .in_real_3 (in_re[3]),
        .in_im_0   (in_imv[0]),
        .in_im_1   (in_imv[1]),
        .in_im_2   (in_imv[2]),
        .in_im_3   (in_imv[3]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_real  (out_real),
        .out_im    (out_im),
        .out_index (out_index),
        .out_last  (out_last),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Cycle counter used for relative timing checks.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: compares every output transfer against the expected queue.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_value("unexpected_out", {60'd0, out_index}, 64'hFFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_value("out_real", {32'd0, out_real}, {32'd0, e.re});
                check_value("out_im", {32'd0, out_im}, {32'd0, e.im});
                check_value("out_index", {60'd0, out_index}, {60'd0, e.idx});
                check_value("out_last", {63'd0, out_last}, {63'd0, e.last});
                if (e.last) last_cyc = cyc;
            end
        end
    end

    // Drives one beat from posedge+1 and returns at posedge+1 after its transfer.
    task automatic send_beat(input int b, input bit sof, input int base);
        int t;
        in_valid = 1'b1;
        in_sof   = sof;
        for (int l = 0; l < 4; l++) begin
            in_re[l]  = base + 4 * l + b;
            in_imv[l] = base + 4 * l + b;
        end
        t = 0;
        @(negedge clk);
        if (!in_ready) stalls++;
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check_value("beat_timeout", 64'd0, 64'd1);
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic push_frame(input int base);
        for (int k = 0; k < 16; k++) begin
            exp_t e;
            e.re   = base + k;
            e.im   = base + k;
            e.idx  = 4'(k);
            e.last = (k == 15);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_frame(input int base);
        for (int b = 0; b < 4; b++) send_beat(b, (b == 0), base);
        push_frame(base);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check_value("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        int cnt;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        for (int l = 0; l < 4; l++) begin
            in_re[l]  = '0;
            in_imv[l] = '0;
        end

        // 1. reset state and idle after release
        @(posedge clk);
        #1;
        check_value("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check_value("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check_value("rst_frame_err", {63'd0, frame_err}, 64'd0);
        check_value("rst_out_index", {60'd0, out_index}, 64'd0);
        check_value("rst_out_last", {63'd0, out_last}, 64'd0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_value("idle_out_valid", {63'd0, out_valid}, 64'd0);
        check_value("idle_in_ready", {63'd0, in_ready}, 64'd1);

        // 2. single frame with latency check
        for (int b = 0; b < 3; b++) send_beat(b, (b == 0), 0);
        check_value("pre_lat_valid", {63'd0, out_valid}, 64'd0);
        send_beat(3, 1'b0, 0);
        check_value("lat_valid", {63'd0, out_valid}, 64'd1);
        push_frame(0);
        drain();

        // 3. back-to-back frames, continuous output
        stalls = 0;
        send_frame(0);
        cnt = 0;
        fork
            send_frame(100);
            begin
                for (int i = 0; i < 32; i++) begin
                    @(negedge clk);
                    if (out_valid) cnt++;
                end
            end
        join
        check_value("b2b_stalls", 64'(stalls), 64'd0);
        check_value("b2b_continuous", 64'(cnt), 64'd32);
        drain();

        // 4. back-pressure with a stalled ninth beat
        out_ready = 1'b0;
        stalls = 0;
        send_frame(200);
        send_frame(300);
        check_value("bp_in_ready", {63'd0, in_ready}, 64'd0);
        fork
            send_beat(0, 1'b1, 400);
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        check_value("bp_stalled", 64'(stalls), 64'd1);
        check_value("bp_beat9_timing", 64'(acc_cyc - last_cyc), 64'd1);
        for (int b = 1; b < 4; b++) send_beat(b, 1'b0, 400);
        push_frame(400);
        drain();

        // 5. mid-frame start-of-frame
        send_beat(0, 1'b1, 500);
        send_beat(1, 1'b0, 500);
        check_value("pre_frame_err", {63'd0, frame_err}, 64'd0);
        send_frame(600);
        check_value("frame_err_set", {63'd0, frame_err}, 64'd1);
        drain();
        check_value("frame_err_sticky", {63'd0, frame_err}, 64'd1);

        // 6. reset in the middle of output
        send_frame(700);
        t = 0;
        @(negedge clk);
        while (!(out_valid && out_index == 4'd7) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_value("mid_index_seen", {60'd0, out_index}, 64'd7);
        #1;
        reset = 1'b0;
        #1;
        check_value("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check_value("mid_rst_ready", {63'd0, in_ready}, 64'd1);
        check_value("mid_rst_index", {60'd0, out_index}, 64'd0);
        check_value("mid_rst_ferr", {63'd0, frame_err}, 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_value("post_rst_valid", {63'd0, out_valid}, 64'd0);
        send_frame(800);
        drain();
        check_value("end_out_valid", {63'd0, out_valid}, 64'd0);
        check_value("end_in_ready", {63'd0, in_ready}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
